// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 -- UART receiver for 8 data bits, 1 stop bit, LSB first.
//
// Optional even parity (8E1 frames) is enabled by defining UART_RX_PARITY_EN.
// In the default build the frame is 8N1 and parity_err is constant 0.
//
// Parameters:
//   CLK_HZ     input clock frequency in Hz
//   BAUD       serial bit rate
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial input, idle high
//   rx_data    last correctly framed byte
//   rx_valid   one-cycle pulse when rx_data is updated
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   parity_err one-cycle pulse on an even-parity mismatch (0 without parity)
//   busy       high whenever the receiver FSM is not idle
module uart_rx_8n1 #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CNT_W      = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t           state, state_next;
  logic             rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       data_next;
  logic             valid_next, ferr_next;
  logic             cnt_done;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_next, perr_next;
`endif

  // A loaded value of N expires on the Nth clock, so the counter is done at 1.
  assign cnt_done = (cnt <= CNT_W'(1));
  assign busy     = (state != IDLE);

  // Two-flop synchronizer plus one history flop for falling-edge detection;
  // all idle-high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // State register and datapath registers; outputs are registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      rx_data   <= data_next;
      rx_valid  <= valid_next;
      frame_err <= ferr_next;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_next;
      parity_err <= perr_next;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Next-state and datapath logic. Only IDLE looks for a start edge, so a
  // falling edge inside a frame never restarts reception.
  always_comb begin
    state_next   = state;
    cnt_next     = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    data_next    = rx_data;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next     = par_bit;
    perr_next    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s2) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_done) begin
          if (!rx_s2) begin
            state_next   = DATA;
            cnt_next     = BIT_LOAD;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_done) begin
          shift_next   = {rx_s2, shift_reg[7:1]};
          cnt_next     = BIT_LOAD;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_done) begin
          par_next   = rx_s2;
          cnt_next   = BIT_LOAD;
          state_next = STOP;
        end
`else
        state_next = IDLE;
`endif
      end
      STOP: begin
        if (cnt_done) begin
          cnt_next = '0;
          if (!rx_s2) begin
            // A bad stop bit outranks a parity error.
            ferr_next  = 1'b1;
            state_next = BREAK;
          end else begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            if ((^shift_reg) ^ par_bit) begin
              perr_next = 1'b1;
            end else begin
              valid_next = 1'b1;
              data_next  = shift_reg;
            end
`else
            valid_next = 1'b1;
            data_next  = shift_reg;
`endif
          end
        end
      end
      BREAK: begin
        if (rx_s2) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1 -- randomized self-checking bench for uart_rx_8n1.
// Frames are driven bit by bit; a frame-level model predicts the outcome
// of every frame from its data, parity and stop bits, and a monitor
// collects the pulses the receiver actually produced.
module tb_uart_rx_8n1;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 10_000;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_data_q[$];
  logic [7:0] exp_data_q[$];
  int         ferr_cnt   = 0;
  int         perr_cnt   = 0;
  int         excl_viol  = 0;
  int         exp_ferr   = 0;
  int         exp_perr   = 0;
  logic [7:0] last_data  = 8'h00;

  uart_rx_8n1 #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pulse monitor, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (rx_valid) got_data_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1) excl_viol++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Frame-level reference: bad stop wins, then even parity, else a new byte.
  task automatic model_frame(input logic [7:0] d, input logic stop_bit,
                             input logic par_bit);
    if (!stop_bit) begin
      exp_ferr++;
    end
`ifdef UART_RX_PARITY_EN
    else if (((^d) ^ par_bit) != 1'b0) begin
      exp_perr++;
    end
`endif
    else begin
      exp_data_q.push_back(d);
      last_data = d;
    end
    if (par_bit === 1'bx) exp_perr = -1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic stop_bit,
                               input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`endif
    send_bit(stop_bit);
    model_frame(d, stop_bit, par_bit);
  endtask

  task automatic verify_results(input string tag);
    checkOutput({tag, " valid count"}, got_data_q.size(), exp_data_q.size());
    while (got_data_q.size() > 0 && exp_data_q.size() > 0)
      checkOutput({tag, " data"}, got_data_q.pop_front(), exp_data_q.pop_front());
    got_data_q.delete();
    exp_data_q.delete();
    checkOutput({tag, " frame_err count"}, ferr_cnt, exp_ferr);
    checkOutput({tag, " parity_err count"}, perr_cnt, exp_perr);
  endtask

  initial begin
    int         busy_dur;
    logic [7:0] d;
    logic       stop_bit;
    logic       par;

    $display("[TB] starting uart_rx_8n1 bench, %0d clk per bit", BIT);

    // Reset state
    repeat (5) @(negedge clk);
    checkOutput("reset rx_data", rx_data, 8'h00);
    checkOutput("reset rx_valid", rx_valid, 1'b0);
    checkOutput("reset frame_err", frame_err, 1'b0);
    checkOutput("reset parity_err", parity_err, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(2 * BIT);
    checkOutput("idle busy", busy, 1'b0);

    // Single good byte
    applyStimulus(8'h55, 1'b1, ^8'h55);
    idle(BIT);
    verify_results("byte 55");
    checkOutput("byte 55 rx_data", rx_data, 8'h55);
    checkOutput("byte 55 busy after", busy, 1'b0);

    // Back-to-back ASCII digits
    for (int b = 8'h30; b <= 8'h39; b++) begin
      d = 8'(b);
      applyStimulus(d, 1'b1, ^d);
    end
    idle(BIT);
    verify_results("digits");

    // Random frames with occasional bad stop or parity bits
    for (int i = 0; i < 12; i++) begin
      d        = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 3) != 0);
      par      = (^d) ^ ($urandom_range(0, 3) == 0);
      applyStimulus(d, stop_bit, par);
      if (!stop_bit) begin
        rx = 1'b0;
        repeat ($urandom_range(0, 2 * BIT)) @(negedge clk);
        idle(BIT);
      end else begin
        idle($urandom_range(1, BIT));
      end
    end
    idle(BIT);
    verify_results("random");

    // False start: short low glitch shorter than half a bit
    busy_dur = 0;
    rx = 1'b0;
    for (int i = 0; i < 24 + 2 * BIT; i++) begin
      if (i == 24) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_dur++;
    end
    checkOutput("false start busy cycles", busy_dur, HALF);
    verify_results("false start");

    // Bad stop bit followed by a long break
    applyStimulus(8'hA3, 1'b0, ^8'hA3);
    rx = 1'b0;
    repeat (4 * BIT) @(negedge clk);
    checkOutput("break busy held", busy, 1'b1);
    checkOutput("break rx_data kept", rx_data, last_data);
    verify_results("break");
    idle(BIT);
    checkOutput("break released busy", busy, 1'b0);
    applyStimulus(8'hC6, 1'b1, ^8'hC6);
    idle(BIT);
    verify_results("after break");

    // Reset in the middle of bit 4 of 8'hFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midframe reset rx_data", rx_data, 8'h00);
    checkOutput("midframe reset rx_valid", rx_valid, 1'b0);
    checkOutput("midframe reset frame_err", frame_err, 1'b0);
    checkOutput("midframe reset busy", busy, 1'b0);
    last_data = 8'h00;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * BIT);
    applyStimulus(8'h12, 1'b1, ^8'h12);
    idle(BIT);
    verify_results("after reset");
    checkOutput("after reset rx_data", rx_data, 8'h12);

`ifdef UART_RX_PARITY_EN
    // 8'h31 has three ones, so even parity needs a 1
    applyStimulus(8'h31, 1'b1, 1'b0);
    idle(BIT);
    applyStimulus(8'h31, 1'b1, 1'b1);
    idle(BIT);
    verify_results("parity 31");
    checkOutput("parity 31 rx_data", rx_data, 8'h31);
`endif

    checkOutput("exclusive pulses", excl_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
